// File: rtl/spi_pkg.sv
// Shared constants and the frame state type for the SPI register slave.
package spi_pkg;

  localparam int CMD_BITS  = 8;
  localparam int RW_BIT    = 7;
  localparam int ADDR_BITS = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, with single-clk
// rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= IDLE_VAL;
      sync_q <= IDLE_VAL;
      prev_q <= IDLE_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign lvl  = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave: 8-bit command (bit7 = write, bits[6:0] = addr)
// followed by WIDTH-bit data word(s). All SPI pins are oversampled by clk.
// Optional macro SPI_AUTOINC_EN: keep transferring words with the address
// incremented modulo NREGS until ce0 rises; otherwise one word per frame.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | deselected, waiting for synchronised ce0 fall
// CMD     | shifting in the 8 command bits on sclk rising edges
// DATA    | shifting the data word: mosi in on rise, miso out on fall
// DONE    | word finished, sclk ignored until ce0 deasserts
module spi_reg_slave
  import spi_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               NREGS     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sclk,
  input  logic                   mosi,
  input  logic                   ce0,
  output logic                   miso,
  output logic [NREGS*WIDTH-1:0] regs_o,
  output logic                   wr_strobe,
  output logic [ADDR_BITS-1:0]   wr_addr,
  output logic                   busy
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ce0_lvl, ce0_rise, ce0_fall;
  logic mosi_meta_q, mosi_s;

  spi_state_e                 state_q, state_d;
  logic [5:0]                 bit_cnt_q, bit_cnt_d;
  logic [CMD_BITS-2:0]        cmd_q, cmd_d;
  logic [ADDR_BITS-1:0]       addr_q, addr_d;
  logic                       is_wr_q, is_wr_d;
  logic                       load_q, load_d;
  logic [WIDTH-2:0]           rx_q, rx_d;
  logic [WIDTH-1:0]           tx_q, tx_d;
  logic                       miso_q, miso_d;
  logic [NREGS*WIDTH-1:0]     regs_q, regs_d;
  logic                       wr_strobe_q, wr_strobe_d;
  logic [ADDR_BITS-1:0]       wr_addr_q, wr_addr_d;

  logic [CMD_BITS-1:0]        cmd_next;
  logic [WIDTH-1:0]           rx_next;
  logic [WIDTH-1:0]           rd_word;
  logic                       addr_ok;
  logic                       unused_ok;

  spi_sync_edge #(.IDLE_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk),
    .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.IDLE_VAL(1'b1)) u_sync_ce0 (
    .clk(clk), .rst_n(rst_n), .d(ce0),
    .lvl(ce0_lvl), .rise(ce0_rise), .fall(ce0_fall)
  );

  // Abort is driven by the ce0 level, so its rise pulse and the sclk level are spare.
  assign unused_ok = &{1'b0, sclk_lvl, ce0_rise};

  // Plain synchroniser for mosi; its latency matches the sclk edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_meta_q <= 1'b0;
      mosi_s      <= 1'b0;
    end else begin
      mosi_meta_q <= mosi;
      mosi_s      <= mosi_meta_q;
    end
  end

  assign cmd_next = {cmd_q, mosi_s};
  assign rx_next  = {rx_q, mosi_s};

  // Register lookup for the current address; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    addr_ok = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (addr_q == ADDR_BITS'(i)) begin
        rd_word = regs_q[i*WIDTH +: WIDTH];
        addr_ok = 1'b1;
      end
    end
  end

  // Frame sequencing and datapath next-state; ce0 high mid-frame aborts.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    is_wr_d     = is_wr_q;
    load_d      = load_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;

    if (state_q != ST_IDLE && ce0_lvl) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      load_d    = 1'b0;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_d    = 1'b0;
          bit_cnt_d = '0;
          if (ce0_fall) state_d = ST_CMD;
        end
        ST_CMD: begin
          miso_d = 1'b0;
          if (sclk_rise) begin
            cmd_d = cmd_next[CMD_BITS-2:0];
            if (bit_cnt_q == 6'(CMD_BITS-1)) begin
              addr_d    = cmd_next[ADDR_BITS-1:0];
              is_wr_d   = cmd_next[RW_BIT];
              load_d    = 1'b1;
              bit_cnt_d = '0;
              state_d   = ST_DATA;
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
        end
        ST_DATA: begin
          // Reload happens one clk after the last rising edge, well before the next fall.
          if (load_q) begin
            tx_d   = is_wr_q ? '0 : rd_word;
            load_d = 1'b0;
          end else if (sclk_fall) begin
            miso_d = tx_q[WIDTH-1];
            tx_d   = {tx_q[WIDTH-2:0], 1'b0};
          end
          if (sclk_rise) begin
            rx_d = rx_next[WIDTH-2:0];
            if (bit_cnt_q == 6'(WIDTH-1)) begin
              bit_cnt_d = '0;
              if (is_wr_q && addr_ok) begin
                for (int i = 0; i < NREGS; i++) begin
                  if (addr_q == ADDR_BITS'(i)) regs_d[i*WIDTH +: WIDTH] = rx_next;
                end
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
              end
`ifdef SPI_AUTOINC_EN
              addr_d = (int'(addr_q) >= NREGS - 1) ? '0 : addr_q + 7'd1;
              load_d = 1'b1;
`else
              miso_d  = 1'b0;
              state_d = ST_DONE;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
        end
        ST_DONE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      is_wr_q     <= 1'b0;
      load_q      <= 1'b0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      regs_q      <= {NREGS{RESET_VAL}};
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      is_wr_q     <= is_wr_d;
      load_q      <= load_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign miso      = miso_q;
  assign regs_o    = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign busy      = ~ce0_lvl;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave (WIDTH=8, NREGS=4, RESET_VAL=0).
// Expectations follow SPI_AUTOINC_EN when the macro is defined.
module tb_spi_reg_slave;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ce0 = 1'b1;
  logic        miso;
  logic [31:0] regs_o;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  logic [6:0] last_addr = '0;

  spi_reg_slave #(.WIDTH(8), .NREGS(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ce0(ce0),
    .miso(miso), .regs_o(regs_o), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && wr_strobe) begin
      strobe_cnt++;
      last_addr = wr_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    #(HALF);
    m = miso;
    sclk = 1'b1;
    #(HALF);
    sclk = 1'b0;
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [15:0] data, input int nbits,
                       output logic [7:0] cmd_m, output logic [15:0] dat_m,
                       output logic bz1, output logic bz2);
    logic m;
    cmd_m = '0;
    dat_m = '0;
    ce0 = 1'b0;
    @(posedge clk); #1 bz1 = busy;
    @(posedge clk); #1 bz2 = busy;
    @(negedge clk);
    #(HALF);
    for (int i = 7; i >= 0; i--) begin
      spi_bit(cmd[i], m);
      cmd_m[i] = m;
    end
    for (int j = 0; j < nbits; j++) begin
      spi_bit(data[15-j], m);
      dat_m[15-j] = m;
    end
    #(HALF);
    ce0 = 1'b1;
    #(4*HALF);
  endtask

  initial begin
    logic [7:0]  cm;
    logic [15:0] dm;
    logic        b1, b2, m;
    int          sc;

    #23;
    check("rst_regs", regs_o, 32'h0);
    check("rst_miso", {31'b0, miso}, 32'h0);
    check("rst_strobe", {31'b0, wr_strobe}, 32'h0);
    check("rst_wr_addr", {25'b0, wr_addr}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // write 0x81 <- 0xA5
    frame(8'h81, 16'hA500, 8, cm, dm, b1, b2);
    check("busy_1clk", {31'b0, b1}, 32'h0);
    check("busy_2clk", {31'b0, b2}, 32'h1);
    check("wr1_regs", regs_o, 32'h0000A500);
    check("wr1_strobes", strobe_cnt, 32'd1);
    check("wr1_addr", {25'b0, last_addr}, 32'd1);
    check("wr1_busy_end", {31'b0, busy}, 32'h0);

    // read 0x01
    frame(8'h01, 16'h0000, 8, cm, dm, b1, b2);
    check("rd1_cmd_miso", {24'b0, cm}, 32'h0);
    check("rd1_data", {16'b0, dm}, 32'h0000A500);
    check("rd1_strobes", strobe_cnt, 32'd1);

    // out-of-range write and read
    frame(8'h85, 16'hFF00, 8, cm, dm, b1, b2);
    check("oor_wr_strobes", strobe_cnt, 32'd1);
    check("oor_wr_regs", regs_o, 32'h0000A500);
    frame(8'h05, 16'h0000, 8, cm, dm, b1, b2);
    check("oor_rd_data", {16'b0, dm}, 32'h0);

    // aborted write after 4 data bits, then a clean frame
    frame(8'h82, 16'hF000, 4, cm, dm, b1, b2);
    check("abort_regs", regs_o, 32'h0000A500);
    check("abort_strobes", strobe_cnt, 32'd1);
    frame(8'h82, 16'h3C00, 8, cm, dm, b1, b2);
    check("post_abort_regs", regs_o, 32'h003CA500);
    check("post_abort_strobes", strobe_cnt, 32'd2);
    check("post_abort_wr_addr", {25'b0, wr_addr}, 32'd2);
    frame(8'h02, 16'h0000, 8, cm, dm, b1, b2);
    check("post_abort_rd", {16'b0, dm}, 32'h00003C00);

    // two-word write starting at reg 3
    frame(8'h83, 16'h1122, 16, cm, dm, b1, b2);
`ifdef SPI_AUTOINC_EN
    check("inc_regs", regs_o, 32'h113CA522);
    check("inc_strobes", strobe_cnt, 32'd4);
    check("inc_last_addr", {25'b0, last_addr}, 32'd0);
`else
    check("inc_regs", regs_o, 32'h113CA500);
    check("inc_strobes", strobe_cnt, 32'd3);
    check("inc_last_addr", {25'b0, last_addr}, 32'd3);
`endif

    // reset in the middle of a read of reg 1 (0xA5)
    ce0 = 1'b0;
    @(negedge clk);
    #(2*HALF);
    for (int i = 7; i >= 0; i--) spi_bit(i == 0, m);
    spi_bit(1'b0, m);
    spi_bit(1'b0, m);
    #(HALF/2);
    check("mid_rd_miso", {31'b0, miso}, 32'h1);
    check("mid_rd_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_regs", regs_o, 32'h0);
    check("midrst_miso", {31'b0, miso}, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_wr_addr", {25'b0, wr_addr}, 32'h0);
    check("midrst_strobe", {31'b0, wr_strobe}, 32'h0);
    ce0 = 1'b1;
    #(HALF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    sc = strobe_cnt;
    frame(8'h80, 16'h5A00, 8, cm, dm, b1, b2);
    check("recover_regs", regs_o, 32'h0000005A);
    check("recover_strobes", strobe_cnt, sc + 1);
    frame(8'h00, 16'h0000, 8, cm, dm, b1, b2);
    check("recover_rd", {16'b0, dm}, 32'h00005A00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
